// File: rtl/ascon_serial_loader.sv
// Host front end for the bit-serial Ascon core: collects operands through 32-bit writes,
// streams them MSB-first into the core, pulses start and times the run until ready.
module ascon_serial_loader #(
  parameter int unsigned KEY_W        = 128,
  parameter int unsigned NONCE_W      = 128,
  parameter int unsigned AD_W         = 40,
  parameter int unsigned DATA_W       = 104,
  parameter int unsigned START_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_sel,
  input  logic [31:0] cfg_wdata,
  input  logic        go,
  input  logic        decrypt_i,
  input  logic        ascon_readyxSO,
  output logic        core_rst,
  output logic        keyxSI,
  output logic        noncexSI,
  output logic        associated_dataxSI,
  output logic        output_dataxSI,
  output logic        ascon_startxSI,
  output logic        decrypt,
  output logic        busy,
  output logic        done,
  output logic [15:0] cycle_cnt
);

  localparam int unsigned MaxKn = (KEY_W > NONCE_W) ? KEY_W : NONCE_W;
  localparam int unsigned MaxAd = (AD_W > DATA_W) ? AD_W : DATA_W;
  localparam int unsigned MAX_W = (MaxKn > MaxAd) ? MaxKn : MaxAd;
  localparam int unsigned IdxW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned ScW   = $clog2(START_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StCrst, StShift, StStart, StWait, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   i_q;
  logic [IdxW-1:0]   nxt_idx;
  logic [IdxW-1:0]   pos;
  logic [ScW-1:0]    sc_q;
  logic [KEY_W-1:0]   key_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [AD_W-1:0]    ad_q;
  logic [DATA_W-1:0]  data_q;
  logic [MAX_W-1:0]  key_pad, nonce_pad, ad_pad, data_pad;

  // Shadow registers shift in one word per write, MSB word first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      data_q  <= '0;
    end else if (cfg_wr && !busy) begin
      case (cfg_sel)
        2'd0:    key_q   <= KEY_W'({key_q, cfg_wdata});
        2'd1:    nonce_q <= NONCE_W'({nonce_q, cfg_wdata});
        2'd2:    ad_q    <= AD_W'({ad_q, cfg_wdata});
        default: data_q  <= DATA_W'({data_q, cfg_wdata});
      endcase
    end
  end

  // Left-align every register to MAX_W so bits beyond its width read as zero.
  always_comb begin
    key_pad   = MAX_W'(key_q) << (MAX_W - KEY_W);
    nonce_pad = MAX_W'(nonce_q) << (MAX_W - NONCE_W);
    ad_pad    = MAX_W'(ad_q) << (MAX_W - AD_W);
    data_pad  = MAX_W'(data_q) << (MAX_W - DATA_W);
    nxt_idx   = (state_q == StCrst) ? '0 : i_q + 1'b1;
    pos       = IdxW'(MAX_W - 1) - nxt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= StIdle;
      i_q                <= '0;
      sc_q               <= '0;
      core_rst           <= 1'b0;
      keyxSI             <= 1'b0;
      noncexSI           <= 1'b0;
      associated_dataxSI <= 1'b0;
      output_dataxSI     <= 1'b0;
      ascon_startxSI     <= 1'b0;
      decrypt            <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      cycle_cnt          <= '0;
    end else begin
      core_rst <= 1'b0;
      done     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            decrypt  <= decrypt_i;
            busy     <= 1'b1;
            core_rst <= 1'b1;
            state_q  <= StCrst;
          end
        end
        StCrst, StShift: begin
          if (state_q == StShift && i_q == IdxW'(MAX_W - 1)) begin
            keyxSI             <= 1'b0;
            noncexSI           <= 1'b0;
            associated_dataxSI <= 1'b0;
            output_dataxSI     <= 1'b0;
            ascon_startxSI     <= 1'b1;
            sc_q               <= '0;
            state_q            <= StStart;
          end else begin
            i_q                <= nxt_idx;
            keyxSI             <= key_pad[pos];
            noncexSI           <= nonce_pad[pos];
            associated_dataxSI <= ad_pad[pos];
            output_dataxSI     <= data_pad[pos];
            state_q            <= StShift;
          end
        end
        StStart: begin
          if (sc_q == ScW'(START_CYCLES - 1)) begin
            ascon_startxSI <= 1'b0;
            cycle_cnt      <= '0;
            state_q        <= StWait;
          end else begin
            sc_q <= sc_q + 1'b1;
          end
        end
        StWait: begin
          if (ascon_readyxSO) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StDone;
          end else if (cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_serial_loader.sv
// Randomised scoreboard bench for ascon_serial_loader: stimulus pushes expected operations,
// a negedge monitor captures each streamed operation and compares it on done.
module tb_ascon_serial_loader;

  localparam int unsigned KEY_W   = 128;
  localparam int unsigned NONCE_W = 128;
  localparam int unsigned AD_W    = 40;
  localparam int unsigned DATA_W  = 104;
  localparam int unsigned MAX_W   = 128;
  localparam int unsigned S       = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_sel = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        go = 1'b0;
  logic        decrypt_i = 1'b0;
  logic        ascon_readyxSO = 1'b0;
  logic        core_rst, keyxSI, noncexSI, associated_dataxSI, output_dataxSI;
  logic        ascon_startxSI, decrypt, busy, done;
  logic [15:0] cycle_cnt;

  ascon_serial_loader dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_wr             (cfg_wr),
    .cfg_sel            (cfg_sel),
    .cfg_wdata          (cfg_wdata),
    .go                 (go),
    .decrypt_i          (decrypt_i),
    .ascon_readyxSO     (ascon_readyxSO),
    .core_rst           (core_rst),
    .keyxSI             (keyxSI),
    .noncexSI           (noncexSI),
    .associated_dataxSI (associated_dataxSI),
    .output_dataxSI     (output_dataxSI),
    .ascon_startxSI     (ascon_startxSI),
    .decrypt            (decrypt),
    .busy               (busy),
    .done               (done),
    .cycle_cnt          (cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int               go_cyc;
    int               n;
    bit               dec;
    logic [MAX_W-1:0] ks, ns, as, ds;
    logic [15:0]      cnt;
  } exp_t;

  exp_t q[$];

  logic [KEY_W-1:0]   m_key = '0;
  logic [NONCE_W-1:0] m_nonce = '0;
  logic [AD_W-1:0]    m_ad = '0;
  logic [DATA_W-1:0]  m_data = '0;

  function automatic void chk_i(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endfunction

  function automatic void chk_v(input string name, input logic [MAX_W-1:0] got,
                                input logic [MAX_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endfunction

  function automatic void model_apply(input logic [1:0] sel, input logic [31:0] w);
    case (sel)
      2'd0:    m_key   = KEY_W'((256'(m_key) << 32) | 256'(w));
      2'd1:    m_nonce = NONCE_W'((256'(m_nonce) << 32) | 256'(w));
      2'd2:    m_ad    = AD_W'((256'(m_ad) << 32) | 256'(w));
      default: m_data  = DATA_W'((256'(m_data) << 32) | 256'(w));
    endcase
  endfunction

  task automatic wr(input logic [1:0] sel, input logic [31:0] w);
    cfg_wr = 1'b1;
    cfg_sel = sel;
    cfg_wdata = w;
    model_apply(sel, w);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk_i({tag, "_core_rst"}, int'(core_rst), 0);
    chk_i({tag, "_key_si"}, int'(keyxSI), 0);
    chk_i({tag, "_nonce_si"}, int'(noncexSI), 0);
    chk_i({tag, "_ad_si"}, int'(associated_dataxSI), 0);
    chk_i({tag, "_data_si"}, int'(output_dataxSI), 0);
    chk_i({tag, "_start"}, int'(ascon_startxSI), 0);
    chk_i({tag, "_decrypt"}, int'(decrypt), 0);
    chk_i({tag, "_busy"}, int'(busy), 0);
    chk_i({tag, "_done"}, int'(done), 0);
    chk_i({tag, "_cycle_cnt"}, int'(cycle_cnt), 0);
  endtask

  // One full operation; ready rises so that it is first seen in WAIT cycle n.
  task automatic run_op(input bit dec, input int n, input bit inject, input bit wr_with_go);
    exp_t e;
    int   lim;
    int   inj;
    bit   got;
    if (wr_with_go) begin
      cfg_wr = 1'b1;
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_wdata = $urandom;
      model_apply(cfg_sel, cfg_wdata);
    end
    go = 1'b1;
    decrypt_i = dec;
    e.go_cyc = cyc;
    e.n = n;
    e.dec = dec;
    e.ks = MAX_W'(m_key) << (MAX_W - KEY_W);
    e.ns = MAX_W'(m_nonce) << (MAX_W - NONCE_W);
    e.as = MAX_W'(m_ad) << (MAX_W - AD_W);
    e.ds = MAX_W'(m_data) << (MAX_W - DATA_W);
    e.cnt = (n > 65535) ? 16'hFFFF : 16'(n);
    q.push_back(e);
    @(posedge clk); #1;
    go = 1'b0;
    cfg_wr = 1'b0;
    decrypt_i = 1'($urandom);
    lim = 1 + MAX_W + S + n;
    inj = inject ? int'($urandom_range(0, (lim - 1 < 200) ? lim - 1 : 200)) : -1;
    for (int c = 0; c < lim; c++) begin
      if (c == inj) begin
        cfg_wr = 1'b1;
        go = 1'b1;
        cfg_sel = 2'($urandom_range(0, 3));
        cfg_wdata = $urandom;
        decrypt_i = ~dec;
      end
      @(posedge clk); #1;
      cfg_wr = 1'b0;
      go = 1'b0;
    end
    ascon_readyxSO = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk_i("done_timeout", 0, 1);
    ascon_readyxSO = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor state
  bit               capturing = 1'b0;
  bit               done_prev = 1'b0;
  bit               prev_start;
  bit               dec_seen, busy_cr;
  int               pos, cr_cyc, cr_len, slen, spulse, soff, tail, busy_drop;
  int               stray = 0;
  logic [MAX_W-1:0] ks, ns, as, ds;

  task automatic finish_op();
    exp_t e;
    chk_i("pending_ops", q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk_i("go_to_core_rst", cr_cyc - e.go_cyc, 1);
      chk_i("core_rst_len", cr_len, 1);
      chk_i("busy_at_core_rst", int'(busy_cr), 1);
      chk_i("decrypt_latched", int'(dec_seen), int'(e.dec));
      chk_i("decrypt_at_done", int'(decrypt), int'(e.dec));
      chk_v("key_stream", ks, e.ks);
      chk_v("nonce_stream", ns, e.ns);
      chk_v("ad_stream", as, e.as);
      chk_v("data_stream", ds, e.ds);
      chk_i("serial_after_shift", tail, 0);
      chk_i("start_offset", soff, MAX_W + 1);
      chk_i("start_len", slen, S);
      chk_i("start_pulses", spulse, 1);
      chk_i("busy_dropped", busy_drop, 0);
      chk_i("busy_at_done", int'(busy), 0);
      chk_i("done_latency", cyc - e.go_cyc, 3 + MAX_W + S + e.n);
      chk_i("cycle_cnt", int'(cycle_cnt), int'(e.cnt));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        capturing = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (done_prev) chk_i("done_one_cycle", int'(done), 0);
        done_prev = done;
        if (core_rst && !capturing) begin
          capturing = 1'b1;
          cr_cyc = cyc;
          cr_len = 0;
          pos = 0;
          ks = '0; ns = '0; as = '0; ds = '0;
          slen = 0; spulse = 0; soff = -1; tail = 0; busy_drop = 0;
          prev_start = 1'b0;
          dec_seen = decrypt;
          busy_cr = busy;
        end
        if (capturing) begin
          if (core_rst) begin
            cr_len++;
          end else begin
            if (!busy && !done) busy_drop++;
            if (pos < MAX_W) begin
              ks[MAX_W-1-pos] = keyxSI;
              ns[MAX_W-1-pos] = noncexSI;
              as[MAX_W-1-pos] = associated_dataxSI;
              ds[MAX_W-1-pos] = output_dataxSI;
              pos++;
            end else if (keyxSI || noncexSI || associated_dataxSI || output_dataxSI) begin
              tail++;
            end
            if (ascon_startxSI) begin
              if (!prev_start) begin
                spulse++;
                if (spulse == 1) soff = cyc - cr_cyc;
              end
              slen++;
            end
            prev_start = ascon_startxSI;
            if (done) begin
              finish_op();
              capturing = 1'b0;
            end
          end
        end else if (ascon_startxSI || done) begin
          stray++;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed operation from the known-answer vectors.
    wr(2'd0, 32'h6d4f8bbf); wr(2'd0, 32'h60ec05a0);
    wr(2'd0, 32'h7b201d4e); wr(2'd0, 32'h5b2119ac);
    wr(2'd2, 32'h00000041); wr(2'd2, 32'h53434f4e);
    wr(2'd3, 32'h00000061); wr(2'd3, 32'h73636f6e);
    wr(2'd3, 32'h2d756e69); wr(2'd3, 32'h63617373);
    for (int i = 0; i < 4; i++) wr(2'd1, $urandom);
    run_op(1'b1, 37, 1'b0, 1'b0);
    run_op(1'b0, 3, 1'b1, 1'b0);

    for (int op = 0; op < 8; op++) begin
      int nw;
      nw = int'($urandom_range(0, 5));
      for (int w = 0; w < nw; w++) wr(2'($urandom_range(0, 3)), $urandom);
      run_op(1'($urandom), int'($urandom_range(0, 60)), 1'($urandom), 1'($urandom));
    end

    run_op(1'($urandom), 70000, 1'b1, 1'b0);

    // Abort mid-shift: reset during bit 50.
    go = 1'b1;
    decrypt_i = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (51) @(posedge clk);
    #1;
    chk_i("busy_before_abort", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    m_key = '0; m_nonce = '0; m_ad = '0; m_data = '0;
    repeat (20) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      wr(2'd0, $urandom); wr(2'd1, $urandom); wr(2'd3, $urandom);
    end
    wr(2'd2, $urandom);
    run_op(1'b1, int'($urandom_range(0, 20)), 1'b0, 1'b1);

    repeat (10) @(posedge clk);
    #1;
    chk_i("stray_start_or_done", stray, 0);
    chk_i("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
